// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Scan sequencer placed directly ahead of mux_8x1. It steps the mux select
//   through channels 0..7 and holds each select for SETTLE_CYC cycles. It then
//   samples mux_out into bit k of an 8-bit word. The finished word is offered
//   downstream on a valid/ready handshake.
//
//   Parameters
//     SETTLE_CYC  cycles sel is held before each sample (legal range 1..15)
//
//   Ports
//     clk      in   clock, all state on rising edge
//     rst_n    in   asynchronous active-low reset
//     start    in   begin one scan (only looked at while idle)
//     cont     in   rescan immediately after each handshake
//     mux_out  in   output of mux_8x1
//     sel      out  select to mux_8x1
//     data     out  assembled word, bit k = channel k
//     valid    out  data valid, held until accepted
//     ready    in   downstream accepts when valid && ready at a clock edge
//     busy     out  high from start capture until the final handshake
//     ch_mask  in   channel enable mask (only when MUX_SCAN_MASK_EN is defined)
//
//   Build option
//     MUX_SCAN_MASK_EN  adds ch_mask. Disabled channels are skipped entirely
//                       and read as 0. Without it, all 8 channels are scanned.
//
//   state  | meaning
//   IDLE   | waiting for start, busy low
//   SETTLE | sel driven, counting down the settle time
//   SAMPLE | capture mux_out for the current channel
//   DONE   | word presented, waiting for ready

module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       mux_out,
    output logic [2:0] sel,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy
`ifdef MUX_SCAN_MASK_EN
    ,
    input  logic [7:0] ch_mask
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] shift;
    logic [7:0] mask_q;
    logic [7:0] mask_in;

    logic [2:0] first_ch;
    logic       any_en;
    logic [2:0] next_ch;
    logic       has_next;
    logic [7:0] word_nxt;

`ifdef MUX_SCAN_MASK_EN
    assign mask_in = ch_mask;
`else
    assign mask_in = 8'hFF;
`endif

    // first_ch comes from the live mask so that a start or a cont restart
    // can jump straight to the lowest enabled channel. next_ch uses the
    // mask captured for the scan in progress.
    always_comb begin
        first_ch = 3'd0;
        any_en   = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_in[i]) begin
                first_ch = 3'(i);
                any_en   = 1'b1;
            end
        end
        next_ch  = sel;
        has_next = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(sel))) begin
                next_ch  = 3'(i);
                has_next = 1'b1;
            end
        end
        word_nxt      = shift;
        word_nxt[sel] = mux_out & mask_q[sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= 3'd0;
            data   <= 8'h00;
            valid  <= 1'b0;
            busy   <= 1'b0;
            cnt    <= 4'd0;
            shift  <= 8'h00;
            mask_q <= 8'hFF;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q <= mask_in;
                        shift  <= 8'h00;
                        busy   <= 1'b1;
                        cnt    <= SETTLE_LOAD;
                        sel    <= first_ch;
                        // With an empty mask, one SAMPLE cycle completes an
                        // all-zero word without sampling anything.
                        state  <= any_en ? SETTLE : SAMPLE;
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) state <= SAMPLE;
                    else             cnt   <= cnt - 4'd1;
                end
                SAMPLE: begin
                    shift <= word_nxt;
                    if (has_next) begin
                        sel   <= next_ch;
                        cnt   <= SETTLE_LOAD;
                        state <= SETTLE;
                    end else begin
                        data  <= word_nxt;
                        valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (cont) begin
                            mask_q <= mask_in;
                            shift  <= 8'h00;
                            cnt    <= SETTLE_LOAD;
                            sel    <= first_ch;
                            state  <= any_en ? SETTLE : SAMPLE;
                        end else begin
                            sel   <= 3'd0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] pat = 8'h00;
    logic       mux_out;
    logic [2:0] sel;
    logic [7:0] data;
    logic       valid;
    logic       busy;
`ifdef MUX_SCAN_MASK_EN
    logic [7:0] ch_mask = 8'hFF;
`endif

    logic       start3 = 1'b0;
    logic [7:0] pat3 = 8'h00;
    logic       mux_out3;
    logic [2:0] sel3;
    logic [7:0] data3;
    logic       valid3;
    logic       busy3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs = 0;
    int v3 = 0;
    int e0 = 0;

    // mux_8x1 models
    assign mux_out  = pat[sel];
    assign mux_out3 = pat3[sel3];

    mux_scan_ctrl #(.SETTLE_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .mux_out(mux_out),
        .sel(sel), .data(data), .valid(valid), .ready(ready), .busy(busy)
`ifdef MUX_SCAN_MASK_EN
        , .ch_mask(ch_mask)
`endif
    );

    mux_scan_ctrl #(.SETTLE_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .cont(1'b0), .mux_out(mux_out3),
        .sel(sel3), .data(data3), .valid(valid3), .ready(1'b1), .busy(busy3)
`ifdef MUX_SCAN_MASK_EN
        , .ch_mask(8'hFF)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (valid && ready) hs <= hs + 1;
        if (valid3) v3 <= v3 + 1;
    end

    // Reference timing: every enabled channel costs settle+1 cycles; an
    // empty scan still takes one cycle.
    function automatic int exp_lat(input int n_en, input int settle);
        return (n_en == 0) ? 1 : n_en * (settle + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan();
        start = 1'b1;
        tick();
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_valid(input int budget, output int lat, output bit saw_idle);
        lat = -1;
        saw_idle = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (!busy) saw_idle = 1'b1;
            if (valid) begin
                lat = cyc - e0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({sel, data, valid, busy} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got sel=%0d data=%h valid=%b busy=%b, want all 0", sel, data, valid, busy);
        end
        checks++;
        if ({sel3, data3, valid3, busy3} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs3: got sel=%0d data=%h valid=%b busy=%b, want all 0", sel3, data3, valid3, busy3);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        bit idle;
        pat = 8'hA5;
        ready = 1'b1;
        start_scan();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
        wait_valid(40, lat, idle);
        checks++;
        if (lat !== exp_lat(8, 1)) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, exp_lat(8, 1)); end
        checks++;
        if (data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", data); end
        tick();
        checks++;
        if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_after_hs: got valid=%b busy=%b want 0 0", valid, busy); end
        ready = 1'b0;
    endtask

    task automatic test_random();
        int lat;
        bit idle;
        int d;
        for (int it = 0; it < 6; it++) begin
            pat = 8'($urandom);
            d = $urandom_range(0, 5);
            ready = 1'b0;
            start_scan();
            wait_valid(40, lat, idle);
            checks++;
            if (lat !== exp_lat(8, 1)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, lat, exp_lat(8, 1)); end
            checks++;
            if (data !== pat) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", it, data, pat); end
            for (int k = 0; k < d; k++) begin
                tick();
                checks++;
                if ({valid, busy, sel, data} !== {1'b1, 1'b1, 3'd7, pat}) begin
                    errors++;
                    $display("FAIL rand_hold[%0d]: got valid=%b busy=%b sel=%0d data=%h want 1 1 7 %h", it, valid, busy, sel, data, pat);
                end
            end
            ready = 1'b1;
            tick();
            checks++;
            if ({valid, busy, sel} !== 5'd0) begin
                errors++;
                $display("FAIL rand_release[%0d]: got valid=%b busy=%b sel=%0d want 0 0 0", it, valid, busy, sel);
            end
            ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit idle;
        int hs0;
        int vhigh;
        pat = 8'hA5;
        ready = 1'b0;
        start_scan();
        wait_valid(40, lat, idle);
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL bp_latency: got %0d want 16", lat); end
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({valid, sel, data} !== {1'b1, 3'd7, 8'hA5}) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b sel=%0d data=%h want 1 7 a5", valid, sel, data);
            end
        end
        hs0 = hs;
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b want 0", valid); end
        vhigh = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (valid) vhigh++;
        end
        checks++;
        if (vhigh !== 0 || (hs - hs0) !== 1) begin
            errors++;
            $display("FAIL bp_single_word: got valid_cycles=%0d handshakes=%0d want 0 1", vhigh, hs - hs0);
        end
        checks++;
        if (data !== 8'hA5) begin errors++; $display("FAIL bp_data_retained: got %h want a5", data); end
        ready = 1'b0;
    endtask

    task automatic test_cont();
        int lat;
        bit idle;
        pat = 8'h3C;
        cont = 1'b1;
        ready = 1'b1;
        start_scan();
        wait_valid(40, lat, idle);
        checks++;
        if ({lat, data} !== {32'd16, 8'h3C}) begin errors++; $display("FAIL cont_first: got lat=%0d data=%h want 16 3c", lat, data); end
        tick();
        e0 = cyc;
        pat = 8'hC3;
        cont = 1'b0;
        checks++;
        if ({valid, busy} !== 2'b01) begin errors++; $display("FAIL cont_restart: got valid=%b busy=%b want 0 1", valid, busy); end
        wait_valid(40, lat, idle);
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL cont_second_latency: got %0d want 16", lat); end
        checks++;
        if (data !== 8'hC3) begin errors++; $display("FAIL cont_second_data: got %h want c3", data); end
        checks++;
        if (idle !== 1'b0) begin errors++; $display("FAIL cont_busy_dropped: got busy low seen=%b want 0", idle); end
        tick();
        checks++;
        if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL cont_end: got valid=%b busy=%b want 0 0", valid, busy); end
        ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit idle;
        int hs0;
        pat = 8'($urandom) | 8'h01;
        ready = 1'b1;
        start_scan();
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, data, valid, busy} !== 13'd0) begin
            errors++;
            $display("FAIL midreset_async: got sel=%0d data=%h valid=%b busy=%b want all 0", sel, data, valid, busy);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        hs0 = hs;
        start_scan();
        wait_valid(40, lat, idle);
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL midreset_latency: got %0d want 16", lat); end
        checks++;
        if (data !== pat) begin errors++; $display("FAIL midreset_data: got %h want %h", data, pat); end
        checks++;
        if (hs !== hs0) begin errors++; $display("FAIL midreset_partial: got %0d extra words want 0", hs - hs0); end
        tick();
        ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        int lat;
        bit idle;
        int hs0;
        int e03;
        int lat3;
        int v30;
        pat = 8'($urandom);
        ready = 1'b1;
        hs0 = hs;
        start_scan();
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(40, lat, idle);
        checks++;
        if ({lat, data} !== {32'd16, pat}) begin errors++; $display("FAIL busy_start_word: got lat=%0d data=%h want 16 %h", lat, data, pat); end
        repeat (40) tick();
        checks++;
        if ((hs - hs0) !== 1) begin errors++; $display("FAIL busy_start_count: got %0d words want 1", hs - hs0); end
        ready = 1'b0;

        pat3 = 8'($urandom);
        v30 = v3;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        e03 = cyc;
        lat3 = -1;
        for (int n = 0; n < 60; n++) begin
            if (valid3) begin lat3 = cyc - e03; break; end
            tick();
        end
        checks++;
        if (lat3 !== exp_lat(8, 3)) begin errors++; $display("FAIL settle3_latency: got %0d want %0d", lat3, exp_lat(8, 3)); end
        checks++;
        if (data3 !== pat3) begin errors++; $display("FAIL settle3_data: got %h want %h", data3, pat3); end
        repeat (10) tick();
        checks++;
        if ((v3 - v30) !== 1 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL settle3_single: got words=%0d busy=%b want 1 0", v3 - v30, busy3);
        end
    endtask

`ifdef MUX_SCAN_MASK_EN
    task automatic test_mask();
        logic [7:0] masks [$];
        logic [7:0] m;
        logic [7:0] visited;
        int lat;
        int hi;
        masks.push_back(8'h0F);
        masks.push_back(8'h00);
        for (int it = 0; it < 5; it++) masks.push_back(8'($urandom));
        ready = 1'b0;
        foreach (masks[j]) begin
            m = masks[j];
            pat = (j == 0) ? 8'hFF : 8'($urandom);
            ch_mask = m;
            start_scan();
            visited = 8'h00;
            lat = -1;
            for (int n = 0; n < 40; n++) begin
                visited[sel] = 1'b1;
                if (valid) begin lat = cyc - e0; break; end
                tick();
            end
            hi = 0;
            for (int b = 0; b < 8; b++) if (m[b]) hi = b;
            checks++;
            if (lat !== exp_lat($countones(m), 1)) begin
                errors++;
                $display("FAIL mask_latency[%h]: got %0d want %0d", m, lat, exp_lat($countones(m), 1));
            end
            checks++;
            if (data !== (pat & m)) begin errors++; $display("FAIL mask_data[%h]: got %h want %h", m, data, pat & m); end
            checks++;
            if (visited !== ((m == 8'h00) ? 8'h01 : m)) begin
                errors++;
                $display("FAIL mask_visited[%h]: got %h want %h", m, visited, (m == 8'h00) ? 8'h01 : m);
            end
            checks++;
            if (int'(sel) !== hi) begin errors++; $display("FAIL mask_done_sel[%h]: got %0d want %0d", m, sel, hi); end
            ready = 1'b1;
            tick();
            ready = 1'b0;
        end
        ch_mask = 8'hFF;
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_backpressure();
        test_cont();
        test_reset_mid();
        test_start_ignored();
`ifdef MUX_SCAN_MASK_EN
        test_mask();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
